// File: rtl/core_pkg.sv
// Shared definitions for the 8-bit pipelined core: datapath widths,
// register/data types and the hard-wired zero register address.
package core_pkg;

  localparam int DATA_W = 8;
  localparam int REG_AW = 3;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [REG_AW-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/wb_forward_unit_reg_file.sv
// Register file: synchronous write port, combinational read port with
// write-through bypass. R0 is hard-wired to zero and ignores writes.
module reg_file #(
  parameter int DATA_W = core_pkg::DATA_W,
  parameter int REG_AW = core_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  import core_pkg::*;

  localparam int NREGS = 1 << REG_AW;
  localparam logic [REG_AW-1:0] ADDR_ZERO = REG_AW'(REG_ZERO);

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != ADDR_ZERO)) begin
      regs[waddr] <= wdata;
    end
  end

  // Bypass lets an ID read see a value being committed in the same cycle.
  always_comb begin
    rdata = regs[raddr];
    if (raddr == ADDR_ZERO) begin
      rdata = '0;
    end else if (we && (waddr == raddr)) begin
      rdata = wdata;
    end
  end

endmodule

// File: rtl/wb_forward_unit.sv
// Write-back stage: EX/WB pipeline register, register-file commit,
// EX-operand forwarding and a wrapping retired-write counter.
module wb_forward_unit #(
  parameter int DATA_W = core_pkg::DATA_W,
  parameter int REG_AW = core_pkg::REG_AW,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              EX_Valid,
  input  logic              EX_RegWrite,
  input  logic [REG_AW-1:0] EX_Rd,
  input  logic [DATA_W-1:0] EX_Result,
  input  logic              Flush,
  input  logic [REG_AW-1:0] ID_EX_Rs,
  input  logic              ID_EX_UsesRs,
  input  logic [REG_AW-1:0] ID_Rs,
  output logic [DATA_W-1:0] Read_Data,
  output logic [DATA_W-1:0] EX_WB_Write_Data,
  output logic              Fwd_signal,
  output logic [CNT_W-1:0]  Retired
);
  import core_pkg::*;

  localparam logic [REG_AW-1:0] RD_ZERO = REG_AW'(REG_ZERO);

  logic              wb_valid;
  logic              wb_we;
  logic [REG_AW-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              commit;

  // A flushed EX slot becomes a bubble: it can neither commit nor forward.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
    end else begin
      wb_valid <= EX_Valid & ~Flush;
      wb_we    <= EX_RegWrite & EX_Valid & ~Flush;
      wb_rd    <= EX_Rd;
      wb_data  <= EX_Result;
    end
  end

  assign commit = wb_we & (wb_rd != RD_ZERO);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Retired <= '0;
    end else if (commit) begin
      Retired <= Retired + CNT_W'(1);
    end
  end

  reg_file #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_reg_file (
    .clk   (Clk),
    .reset (Reset),
    .we    (wb_we),
    .waddr (wb_rd),
    .wdata (wb_data),
    .raddr (ID_Rs),
    .rdata (Read_Data)
  );

  // wb_valid alone never matters downstream; wb_we already folds it in.
  assign Fwd_signal       = commit & wb_valid & ID_EX_UsesRs & (wb_rd == ID_EX_Rs);
  assign EX_WB_Write_Data = wb_data;

endmodule

// File: tb/tb_wb_forward_unit.sv
// Bench for wb_forward_unit: a rule-level model checked every cycle plus
// directed scenarios with hand-computed literal expectations.
module tb_wb_forward_unit;
  import core_pkg::*;

  localparam int CNT_W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              ex_valid;
  logic              ex_regwrite;
  reg_addr_t         ex_rd;
  data_t             ex_result;
  logic              flush;
  reg_addr_t         id_ex_rs;
  logic              id_ex_usesrs;
  reg_addr_t         id_rs;
  data_t             read_data;
  data_t             wb_write_data;
  logic              fwd_signal;
  logic [CNT_W-1:0]  retired;

  always #5 clk = ~clk;

  wb_forward_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .Clk              (clk),
    .Reset            (reset),
    .EX_Valid         (ex_valid),
    .EX_RegWrite      (ex_regwrite),
    .EX_Rd            (ex_rd),
    .EX_Result        (ex_result),
    .Flush            (flush),
    .ID_EX_Rs         (id_ex_rs),
    .ID_EX_UsesRs     (id_ex_usesrs),
    .ID_Rs            (id_rs),
    .Read_Data        (read_data),
    .EX_WB_Write_Data (wb_write_data),
    .Fwd_signal       (fwd_signal),
    .Retired          (retired)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  bit check_en     = 1'b0;

  // Model: architectural registers, count, and the result awaiting commit.
  data_t            m_regs [8];
  logic [CNT_W-1:0] m_cnt   = '0;
  bit               m_pwe   = 1'b0;
  int               m_prd   = 0;
  data_t            m_pdata = '0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit v, input bit rw, input int rd, input int res,
                               input bit fl, input int exrs, input bit uses, input int idrs);
    ex_valid     = v;
    ex_regwrite  = rw;
    ex_rd        = reg_addr_t'(rd);
    ex_result    = data_t'(res);
    flush        = fl;
    id_ex_rs     = reg_addr_t'(exrs);
    id_ex_usesrs = uses;
    id_rs        = reg_addr_t'(idrs);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) m_regs[i] = '0;
      m_cnt   = '0;
      m_pwe   = 1'b0;
      m_prd   = 0;
      m_pdata = '0;
    end else begin
      if (m_pwe && m_prd != 0) begin
        m_regs[m_prd] = m_pdata;
        m_cnt         = m_cnt + 1'b1;
      end
      m_pwe   = ex_valid && ex_regwrite && !flush;
      m_prd   = int'(ex_rd);
      m_pdata = ex_result;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      data_t exp_read;
      bit    exp_fwd;
      if (id_rs == 0)                               exp_read = '0;
      else if (m_pwe && m_prd == int'(id_rs))       exp_read = m_pdata;
      else                                          exp_read = m_regs[id_rs];
      exp_fwd = m_pwe && m_prd != 0 && id_ex_usesrs && m_prd == int'(id_ex_rs);
      checkOutput("model_read_data", 32'(read_data), 32'(exp_read));
      checkOutput("model_fwd", 32'(fwd_signal), 32'(exp_fwd));
      checkOutput("model_wb_data", 32'(wb_write_data), 32'(m_pdata));
      checkOutput("model_retired", 32'(retired), 32'(m_cnt));
    end
  end

  initial begin
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    check_en = 1'b1;
    step();
    reset = 1'b0;

    // Idle after reset: everything reads zero.
    for (int i = 1; i < 8; i++) begin
      applyStimulus(0, 0, 0, 0, 0, i, 1, i);
      @(negedge clk);
      checkOutput("idle_read", 32'(read_data), 32'h0);
      checkOutput("idle_fwd", 32'(fwd_signal), 32'h0);
      step();
    end
    checkOutput("idle_retired", 32'(retired), 32'h0);
    checkOutput("idle_wb_data", 32'(wb_write_data), 32'h0);

    // Back-to-back forward: A writes R2=05, B reads R2 in the next cycle.
    applyStimulus(1, 1, 2, 8'h05, 0, 0, 0, 0);
    step();
    applyStimulus(1, 0, 5, 8'h99, 0, 2, 1, 0);
    @(negedge clk);
    checkOutput("fwd_signal", 32'(fwd_signal), 32'h1);
    checkOutput("fwd_data", 32'(wb_write_data), 32'h05);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 2);
    @(negedge clk);
    checkOutput("fwd_r2", 32'(read_data), 32'h05);
    checkOutput("fwd_retired", 32'(retired), 32'h1);
    step();

    // Write-through: R3 commits while ID reads R3.
    applyStimulus(1, 1, 3, 8'hA7, 0, 0, 0, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 3);
    @(negedge clk);
    checkOutput("wt_read", 32'(read_data), 32'hA7);
    step();

    // li consumer does not forward even when Rs matches.
    applyStimulus(1, 1, 6, 8'h11, 0, 0, 0, 0);
    step();
    applyStimulus(1, 1, 1, 8'h00, 0, 6, 0, 0);
    @(negedge clk);
    checkOutput("li_fwd", 32'(fwd_signal), 32'h0);
    step();

    // R0 writer: no forward, no commit, no count.
    applyStimulus(1, 1, 0, 8'h22, 0, 0, 0, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    checkOutput("r0_fwd", 32'(fwd_signal), 32'h0);
    checkOutput("r0_read", 32'(read_data), 32'h0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("r0_retired", 32'(retired), 32'h4);
    step();

    // Flushed producer: bubble.
    applyStimulus(1, 1, 7, 8'h33, 1, 0, 0, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 7, 1, 7);
    @(negedge clk);
    checkOutput("flush_fwd", 32'(fwd_signal), 32'h0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 7);
    @(negedge clk);
    checkOutput("flush_r7", 32'(read_data), 32'h0);
    checkOutput("flush_retired", 32'(retired), 32'h4);
    step();

    // Counter wrap: 65535 commits from zero, then one more.
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 65535; i++) begin
      applyStimulus(1, 1, 1, i & 8'hFF, 0, 0, 0, 0);
      step();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    step();
    @(negedge clk);
    checkOutput("wrap_full", 32'(retired), 32'hFFFF);
    checkOutput("wrap_r1", 32'(read_data), 32'hFE);
    step();
    applyStimulus(1, 1, 2, 8'h5A, 0, 0, 0, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    @(negedge clk);
    checkOutput("wrap_zero", 32'(retired), 32'h0);
    step();

    // Reset while A (R4=3C) sits in EX/WB.
    applyStimulus(1, 1, 4, 8'h3C, 0, 0, 0, 0);
    step();
    reset = 1'b1;
    applyStimulus(1, 1, 5, 8'h44, 0, 4, 1, 0);
    step();
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 4, 1, 4);
    @(negedge clk);
    checkOutput("rst_r4", 32'(read_data), 32'h0);
    checkOutput("rst_fwd", 32'(fwd_signal), 32'h0);
    checkOutput("rst_retired", 32'(retired), 32'h0);
    checkOutput("rst_wb_data", 32'(wb_write_data), 32'h0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 5, 1, 5);
    @(negedge clk);
    checkOutput("rst_r5", 32'(read_data), 32'h0);
    checkOutput("rst_fwd5", 32'(fwd_signal), 32'h0);
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/wb_forward_unit.md
# wb_forward_unit

Write-back stage of the 8-bit pipelined core: latches the EX-stage result into the EX/WB pipeline register and commits it to the 8-entry register file. It also produces the forwarding pair (`EX_WB_Write_Data`, `Fwd_signal`) consumed by the ALU operand mux. It serves the ID-stage register read with write-through bypass and counts retired register writes.

## Interface
Parameters:
- `DATA_W`, 8, datapath width
- `REG_AW`, 3, register address width (2**REG_AW registers)
- `CNT_W`, 16, retired-write counter width

Ports:
- `Clk` in 1: single clock, rising edge
- `Reset` in 1: synchronous, active-high
- `EX_Valid` in 1: EX slot holds a real instruction
- `EX_RegWrite` in 1: EX instruction writes a register
- `EX_Rd` in REG_AW: EX destination register
- `EX_Result` in DATA_W: ALU result
- `Flush` in 1: squash EX instruction (treated as bubble)
- `ID_EX_Rs` in REG_AW: source register of instruction now in EX
- `ID_EX_UsesRs` in 1: EX instruction reads Rs (addi=1, li=0)
- `ID_Rs` in REG_AW: register address read by ID stage
- `Read_Data` out DATA_W: ID-stage register read value
- `EX_WB_Write_Data` out DATA_W: registered write-back data
- `Fwd_signal` out 1: ALU must take `EX_WB_Write_Data` instead of its latched operand
- `Retired` out CNT_W: count of committed register writes

## Operation
- EX/WB register (`wb_valid`, `wb_we`, `wb_rd`, `wb_data`) loads every cycle:
  - `wb_valid <= EX_Valid & ~Flush`
  - `wb_we <= EX_RegWrite & EX_Valid & ~Flush`
  - `wb_rd <= EX_Rd`
  - `wb_data <= EX_Result`
- Commit: when `wb_we` is 1 and `wb_rd` != 0, `regs[wb_rd] <= wb_data` and `Retired <= Retired + 1`.
- `Retired` wraps modulo 2**CNT_W; 16'hFFFF goes to 0, with no sticky flag.
- R0 reads as 0. Writes to R0 are dropped and do not increment `Retired`.
- `Read_Data`, combinational:
  - 0 if `ID_Rs` == 0
  - else `wb_data` if `wb_we` and `wb_rd` == `ID_Rs` (write-through bypass)
  - else `regs[ID_Rs]`
- `Fwd_signal`, combinational = `wb_we & (wb_rd != 0) & ID_EX_UsesRs & (wb_rd == ID_EX_Rs)`.
- `EX_WB_Write_Data` = `wb_data`, always driven, meaningful only when `Fwd_signal` is 1.
- Arithmetic: no carries or overflow handling; data passes through unmodified at DATA_W bits.

## Timing
- Latency: a result presented in cycle n is on `EX_WB_Write_Data` in cycle n+1 and is written to the register file at the end of n+1. Reads from n+2 onward return it from the array.
- Back-to-back dependency: A in EX (cycle n), B in ID (cycle n).
  - Cycle n+1: B is in EX and A is in WB, so `Fwd_signal` = 1 if B.Rs == A.Rd.
- Distance-2 dependency: covered by the `Read_Data` bypass in the commit cycle; `Fwd_signal` stays 0.
- Simultaneous events:
  - Commit and ID read of the same register in the same cycle returns the new value.
  - Flush in the same cycle as `EX_Valid` inserts a bubble: no commit, no forward, no count.
- Reset (any cycle, including mid-dependency) clears the following on the next edge:
  - EX/WB register, all registers, and `Retired` go to 0.
  - `Fwd_signal` = 0 and `EX_WB_Write_Data` = 0 from the first post-reset cycle.
  - A result captured the cycle before reset is never committed.
  - `EX_*` inputs sampled in the reset cycle are ignored.

## Structure
- Shared package `core_pkg` holds:
  - `DATA_W` and `REG_AW`
  - the `reg_addr_t` and `data_t` typedefs
  - the constant `REG_ZERO` = 0
- One sub-module, `reg_file`: 2**REG_AW x DATA_W array, one synchronous write port, one combinational read port with write-through bypass and the R0 rule.
- EX/WB register, forwarding compare and counter stay in `wb_forward_unit`.

## Test plan
- Reset then idle: all outputs 0; reading R1..R7 returns 0; `Retired` = 0.
- Forward: A (EX_Rd=2, result 8'h05, RegWrite) followed by B (ID_EX_Rs=2, UsesRs=1).
  - Required: in B's EX cycle, `Fwd_signal` = 1 and `EX_WB_Write_Data` = 8'h05.
  - Required: R2 = 8'h05 afterwards and `Retired` = 1.
- Write-through: commit R3 = 8'hA7 while `ID_Rs` = 3 in the same cycle. Required: `Read_Data` = 8'hA7 that cycle.
- Non-forwarding cases, each required to give `Fwd_signal` = 0:
  - li consumer (UsesRs=0)
  - Rd=0 writer: no commit, no count increment
  - Flush on the producer: no commit
- Counter wrap: preload `Retired` to 16'hFFFF via 65535 commits, then one more commit. Required: `Retired` = 0.
- Reset mid-operation: assert `Reset` the cycle after A (Rd=4, 8'h3C) enters EX/WB.
  - Required: R4 stays 0, `Fwd_signal` = 0, `Retired` = 0.
